sr_cmd_gen: RTL and testbench

Front-end command stage for the team's SR flip-flop blocks. It takes two raw, asynchronous, bouncy request lines (set and clear) and synchronizes and debounces them. It arbitrates between them and issues clean, registered, mutually exclusive `s` / `r` pulses of programmable width, followed by a programmable hold-off. Its `s`/`r` outputs drive the `s`/`r` inputs of the downstream SR flop directly, and the encoding `s=r=1` is never produced.

---
 rtl/sr_cmd_gen.sv | 197 +++++++++++++++++++
 tb/tb_sr_cmd_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: front-end command stage for an SR flop.
// Synchronizes and debounces two raw request lines (set / clear), turns the
// rising edge of each debounced level into a request, arbitrates, and issues
// mutually exclusive registered s / r pulses of PULSE_W cycles followed by a
// HOLDOFF-cycle idle window.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high reset
//   set_in    in   raw set request (asynchronous, may bounce)
//   clr_in    in   raw clear request (asynchronous, may bounce)
//   s         out  registered set pulse
//   r         out  registered reset pulse
//   busy      out  registered, high whenever the FSM is not idle
//   conflict  out  one-cycle flag: set and clear requested together while idle
//   drop      out  one-cycle flag: request discarded because the FSM was busy

// sr_cmd_gen_chan: one request channel.
// 2-flop synchronizer, debouncer and rising-edge detector.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high reset
//   raw    in   raw asynchronous request line
//   req_c  out  combinational: debounced level rose on the last edge
module sr_cmd_gen_chan #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic req_c
);

  localparam int unsigned DBC_W   = 8;
  localparam logic [DBC_W-1:0] DB_LAST = DBC_W'(DB_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             deb;
  logic             deb_q;
  logic [DBC_W-1:0] dbc;

  // Synchronizer, debounce counter and previous-level register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      deb    <= 1'b0;
      deb_q  <= 1'b0;
      dbc    <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      deb_q  <= deb;
      if (sync_2 == deb) begin
        // Any return to the held level restarts the stability count.
        dbc <= '0;
      end else if (dbc == DB_LAST) begin
        // This cycle completes DB_CYCLES consecutive differing samples.
        deb <= sync_2;
        dbc <= '0;
      end else begin
        dbc <= dbc + DBC_W'(1);
      end
    end
  end

  // Only rising edges of the debounced level are requests.
  assign req_c = deb & ~deb_q;

endmodule

module sr_cmd_gen #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned PULSE_W   = 1,
  parameter int unsigned HOLDOFF   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict,
  output logic drop
);

  localparam int unsigned PC_W = 4;
  localparam int unsigned HC_W = 8;
  localparam logic [PC_W-1:0] PC_INIT = PC_W'(PULSE_W - 1);
  // HC_INIT is never loaded when HOLDOFF is zero; keep it in range anyway.
  localparam logic [HC_W-1:0] HC_INIT = (HOLDOFF == 0) ? '0 : HC_W'(HOLDOFF - 1);
  localparam bit HAS_HOLD = (HOLDOFF != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE_S,
    ST_PULSE_R,
    ST_HOLD
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [HC_W-1:0] hc;
  logic            set_req_c;
  logic            clr_req_c;
  logic            any_req_c;

  sr_cmd_gen_chan #(.DB_CYCLES(DB_CYCLES)) u_set_chan (
    .clk   (clk),
    .reset (reset),
    .raw   (set_in),
    .req_c (set_req_c)
  );

  sr_cmd_gen_chan #(.DB_CYCLES(DB_CYCLES)) u_clr_chan (
    .clk   (clk),
    .reset (reset),
    .raw   (clr_in),
    .req_c (clr_req_c)
  );

  assign any_req_c = set_req_c | clr_req_c;

  // Command FSM with registered outputs. s and r are only ever raised from
  // IDLE in mutually exclusive branches, so s=r=1 cannot occur.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
      drop     <= 1'b0;
      pc       <= '0;
      hc       <= '0;
    end else begin
      conflict <= 1'b0;
      drop     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (set_req_c && clr_req_c) begin
            conflict <= 1'b1;
          end else if (set_req_c) begin
            state <= ST_PULSE_S;
            s     <= 1'b1;
            busy  <= 1'b1;
            pc    <= PC_INIT;
          end else if (clr_req_c) begin
            state <= ST_PULSE_R;
            r     <= 1'b1;
            busy  <= 1'b1;
            pc    <= PC_INIT;
          end
        end

        ST_PULSE_S, ST_PULSE_R: begin
          // Requests while busy are discarded, never queued.
          drop <= any_req_c;
          if (pc == '0) begin
            s <= 1'b0;
            r <= 1'b0;
            if (HAS_HOLD) begin
              state <= ST_HOLD;
              hc    <= HC_INIT;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            pc <= pc - PC_W'(1);
          end
        end

        ST_HOLD: begin
          drop <= any_req_c;
          if (hc == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            hc <= hc - HC_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          s     <= 1'b0;
          r     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Testbench for sr_cmd_gen. Three instances with different pulse widths share
// clock and reset: A (DB=4,PW=1,HO=2), B (DB=4,PW=3,HO=2), C (DB=4,PW=4,HO=2).
// Output vectors are packed as {s, r, busy, conflict, drop}.
module tb_sr_cmd_gen;

  localparam int unsigned DB [3] = '{4, 4, 4};
  localparam int unsigned PW [3] = '{1, 3, 4};
  localparam int unsigned HO [3] = '{2, 2, 2};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] set_v = '0;
  logic [2:0] clr_v = '0;
  logic [2:0] s_v, r_v, busy_v, conf_v, drop_v;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  sr_cmd_gen #(.DB_CYCLES(4), .PULSE_W(1), .HOLDOFF(2)) dut_a (
    .clk(clk), .reset(reset), .set_in(set_v[0]), .clr_in(clr_v[0]),
    .s(s_v[0]), .r(r_v[0]), .busy(busy_v[0]), .conflict(conf_v[0]), .drop(drop_v[0])
  );

  sr_cmd_gen #(.DB_CYCLES(4), .PULSE_W(3), .HOLDOFF(2)) dut_b (
    .clk(clk), .reset(reset), .set_in(set_v[1]), .clr_in(clr_v[1]),
    .s(s_v[1]), .r(r_v[1]), .busy(busy_v[1]), .conflict(conf_v[1]), .drop(drop_v[1])
  );

  sr_cmd_gen #(.DB_CYCLES(4), .PULSE_W(4), .HOLDOFF(2)) dut_c (
    .clk(clk), .reset(reset), .set_in(set_v[2]), .clr_in(clr_v[2]),
    .s(s_v[2]), .r(r_v[2]), .busy(busy_v[2]), .conflict(conf_v[2]), .drop(drop_v[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs(input int i);
    return {s_v[i], r_v[i], busy_v[i], conf_v[i], drop_v[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Debounced level flips once the last DB synchronized samples all carry the
  // opposite value; an accepted request occupies the block for PW+HO cycles,
  // the first PW of which drive the output.
  bit          m_s1   [3][2];
  bit          m_s2   [3][2];
  bit          m_deb  [3][2];
  bit          m_prev [3][2];
  logic [31:0] m_hist [3][2];
  int          m_nh   [3][2];
  int          m_pl   [3];
  int          m_bl   [3];
  bit          m_kind [3];
  bit          m_conf [3];
  bit          m_drop [3];

  function automatic logic [4:0] m_exp(input int i);
    return {(m_pl[i] > 0) && !m_kind[i], (m_pl[i] > 0) && m_kind[i],
            m_bl[i] > 0, m_conf[i], m_drop[i]};
  endfunction

  always @(posedge clk) begin : model
    bit          rq [2];
    bit          raw [2];
    logic [31:0] mask;
    for (int i = 0; i < 3; i++) begin
      raw[0] = set_v[i];
      raw[1] = clr_v[i];
      if (reset) begin
        for (int c = 0; c < 2; c++) begin
          m_s1[i][c] = 0; m_s2[i][c] = 0; m_deb[i][c] = 0; m_prev[i][c] = 0;
          m_hist[i][c] = '0; m_nh[i][c] = 0;
        end
        m_pl[i] = 0; m_bl[i] = 0; m_kind[i] = 0; m_conf[i] = 0; m_drop[i] = 0;
      end else begin
        for (int c = 0; c < 2; c++) rq[c] = m_deb[i][c] && !m_prev[i][c];
        m_conf[i] = 0;
        m_drop[i] = 0;
        if (m_bl[i] > 0) begin
          if (rq[0] || rq[1]) m_drop[i] = 1;
          m_bl[i]--;
          if (m_pl[i] > 0) m_pl[i]--;
        end else if (rq[0] && rq[1]) begin
          m_conf[i] = 1;
        end else if (rq[0] || rq[1]) begin
          m_kind[i] = rq[1];
          m_pl[i]   = int'(PW[i]);
          m_bl[i]   = int'(PW[i] + HO[i]);
        end
        mask = (32'd1 << DB[i]) - 32'd1;
        for (int c = 0; c < 2; c++) begin
          m_prev[i][c] = m_deb[i][c];
          m_hist[i][c] = {m_hist[i][c][30:0], m_s2[i][c]};
          if (m_nh[i][c] < 32) m_nh[i][c]++;
          if (m_nh[i][c] >= int'(DB[i]) &&
              (m_hist[i][c] & mask) == (m_deb[i][c] ? 32'd0 : mask))
            m_deb[i][c] = !m_deb[i][c];
          m_s2[i][c] = m_s1[i][c];
          m_s1[i][c] = raw[c];
        end
      end
    end
  end

  // ---------------- model compare and pulse-shape monitor ----------------
  int run [3] = '{0, 0, 0};
  int gap [3] = '{0, 0, 0};
  bit had [3] = '{0, 0, 0};
  int pulses = 0;

  always @(negedge clk) begin
    if (cmp_en)
      for (int i = 0; i < 3; i++)
        chk($sformatf("model_%0d", i), 32'(outs(i)), 32'(m_exp(i)));
    if (mon_en)
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("s_and_r_%0d", i), 32'(s_v[i] & r_v[i]), 32'd0);
        if (s_v[i] | r_v[i]) begin
          if (run[i] == 0 && had[i])
            chk($sformatf("gap_%0d", i), 32'(gap[i] >= int'(HO[i])), 32'd1);
          run[i]++;
        end else begin
          if (run[i] > 0) begin
            chk($sformatf("width_%0d", i), 32'(run[i]), 32'(PW[i]));
            pulses++;
            had[i] = 1;
            run[i] = 0;
            gap[i] = 0;
          end
          gap[i]++;
        end
      end
  end

  // ---------------- directed vectors for instance A ----------------
  typedef struct {
    bit         rst;
    bit         set;
    bit         clr;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit st, input bit cl, input logic [4:0] e, input int n);
    vec_t v;
    v.rst = rst; v.set = st; v.clr = cl; v.exp = e;
    repeat (n) vecs.push_back(v);
  endtask

  initial begin
    int first, cnt, bad;
    logic [4:0] e;

    // Reset, then set held high: s for one cycle at edge 7, busy for 3.
    add(1, 0, 0, 5'b00000, 2);
    add(0, 1, 0, 5'b00000, 6);
    add(0, 1, 0, 5'b10100, 1);
    add(0, 1, 0, 5'b00100, 2);
    add(0, 1, 0, 5'b00000, 3);
    // Release set; falling edges are silent.
    add(0, 0, 0, 5'b00000, 8);
    // Simultaneous rise: conflict only, at edge 7.
    add(0, 1, 1, 5'b00000, 6);
    add(0, 1, 1, 5'b00010, 1);
    add(0, 1, 1, 5'b00000, 3);
    add(0, 0, 0, 5'b00000, 8);

    foreach (vecs[k]) begin
      reset    = vecs[k].rst;
      set_v[0] = vecs[k].set;
      clr_v[0] = vecs[k].clr;
      tick();
      chk($sformatf("vec_%0d", k), 32'(outs(0)), 32'(vecs[k].exp));
    end

    // Bounce on clr: 3-high / 1-low bursts stay invisible.
    bad = 0;
    for (int g = 0; g < 3; g++)
      for (int k = 0; k < 4; k++) begin
        clr_v[0] = (k < 3);
        tick();
        if (outs(0) != 5'b00000) bad++;
      end
    chk("bounce_quiet", 32'(bad), 32'd0);
    first = 0;
    cnt   = 0;
    for (int t = 1; t <= 16; t++) begin
      clr_v[0] = 1'b1;
      tick();
      if (r_v[0]) begin
        if (first == 0) first = t;
        cnt++;
      end
    end
    chk("bounce_r_edge", 32'(first), 32'd7);
    chk("bounce_r_count", 32'(cnt), 32'd1);
    clr_v[0] = 1'b0;
    repeat (10) tick();

    // Instance B: clr's debounced edge lands in HOLD after a 3-cycle s pulse.
    for (int t = 1; t <= 14; t++) begin
      set_v[1] = 1'b1;
      clr_v[1] = (t >= 5);
      tick();
      e = {t >= 7 && t <= 9, 1'b0, t >= 7 && t <= 11, 1'b0, t == 11};
      chk($sformatf("hold_drop_%0d", t), 32'(outs(1)), 32'(e));
    end
    clr_v[1] = 1'b0;
    repeat (10) tick();
    for (int t = 1; t <= 12; t++) begin
      clr_v[1] = 1'b1;
      tick();
      e = {1'b0, t >= 7 && t <= 9, t >= 7 && t <= 11, 1'b0, 1'b0};
      chk($sformatf("fresh_clr_%0d", t), 32'(outs(1)), 32'(e));
    end
    set_v[1] = 1'b0;
    clr_v[1] = 1'b0;
    repeat (10) tick();

    // Instance C: reset during the second cycle of a 4-cycle s pulse.
    for (int t = 1; t <= 8; t++) begin
      set_v[2] = 1'b1;
      tick();
      e = {t >= 7, 1'b0, t >= 7, 1'b0, 1'b0};
      chk($sformatf("pre_rst_%0d", t), 32'(outs(2)), 32'(e));
    end
    reset = 1'b1;
    tick();
    chk("rst_mid_pulse", 32'(outs(2)), 32'd0);
    reset = 1'b0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      e = {t >= 7 && t <= 10, 1'b0, t >= 7 && t <= 12, 1'b0, 1'b0};
      chk($sformatf("post_rst_%0d", t), 32'(outs(2)), 32'(e));
    end
    set_v[2] = 1'b0;
    repeat (10) tick();

    // Random bouncing on all inputs, checked against the model.
    reset = 1'b1;
    repeat (2) tick();
    reset  = 1'b0;
    cmp_en = 1'b1;
    mon_en = 1'b1;
    repeat (10000) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(5) == 0) set_v[i] = ~set_v[i];
        if ($urandom_range(5) == 0) clr_v[i] = ~clr_v[i];
      end
      tick();
    end
    set_v = '0;
    clr_v = '0;
    repeat (40) tick();
    cmp_en = 1'b0;
    mon_en = 1'b0;
    chk("rand_pulses_seen", 32'(pulses != 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
